// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension block: mode encodings used by
// both the extension datapath and any decode that produces in_mode.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,  // zero-pad to output width
    MODE_SIGN   = 2'b01,  // sign-extend from the top input bit
    MODE_UPPER  = 2'b10,  // place in the top bits, low bits zero
    MODE_BRANCH = 2'b11   // sign-extend then shift left by 2 (word offset)
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: IN_W raw bits -> OUT_W value.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  // Select the extension form; branch reuses the sign-extended value.
  always_comb begin
    ext_o = '0;
    case (imm_mode_e'(mode_i))
      MODE_ZERO:   ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      MODE_SIGN:   ext_o = sext;
      MODE_UPPER:  ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
      default:     ext_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends on input, buffers extended results in a
// small FIFO with valid/ready handshakes, and counts delivered results.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [7:0]       count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Reject illegal parameter sets at elaboration.
  if (OUT_W < IN_W + 2 || DEPTH < 1) begin : g_bad_params
    $error("imm_extend_unit: need OUT_W >= IN_W+2 and DEPTH >= 1");
  end

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       count_q, count_d;
  logic [OUT_W-1:0] ext_val;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm_i  (in_imm),
    .mode_i (in_mode),
    .ext_o  (ext_val)
  );

  // When full, a simultaneous pop frees the head slot, so input may pass through.
  assign in_ready  = (occ_q < OCC_FULL) || out_ready;
  assign out_valid = (occ_q != '0);
  assign out_imm   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers, occupancy and delivered-result counter.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = pop  ? count_q + 8'd1    : count_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO state; storage is cleared on reset so out_imm reads zero until written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= ext_val;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: default build (16->32, depth 2) plus a
// 12->32 build sharing clock and reset.
module tb_imm_extend_unit;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_imm;
  logic [7:0]  count;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [11:0] in_imm2;
  logic [1:0]  in_mode2;
  logic [31:0] out_imm2;
  logic [7:0]  count2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_extend_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .count(count)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(32), .DEPTH(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_imm(in_imm2), .in_mode(in_mode2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_imm(out_imm2), .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp16 [4];

  initial begin
    exp16[0] = 32'h00008001; exp16[1] = 32'hFFFF8001;
    exp16[2] = 32'h80010000; exp16[3] = 32'hFFFE0004;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_imm = '0; in_mode = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; in_imm2 = '0; in_mode2 = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_count",     {24'd0, count},     32'd0);
    chk("rst_out_imm",   out_imm,            32'd0);

    // Each mode on 16'h8001, one cycle latency, consumer always ready.
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(m);
      tick();
      in_valid = 1'b0; in_imm = 16'h1234;
      #1;
      chk("mode_valid", {31'd0, out_valid}, 32'd1);
      chk("mode_value", out_imm, exp16[m]);
      tick();
    end
    chk("mode_count", {24'd0, count}, 32'd4);

    // Stall: fill with two, third held, then drain in order.
    out_ready = 1'b0; in_mode = MODE_ZERO;
    in_valid = 1'b1; in_imm = 16'h0011; tick();
    in_imm = 16'h0022; tick();
    in_imm = 16'h0033; #1;
    chk("stall_full_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_head", out_imm, 32'h11);
    tick();
    chk("stall_head_stable", out_imm, 32'h11);
    chk("stall_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; #1;
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("drain_b", out_imm, 32'h22);
    tick();
    chk("drain_c", out_imm, 32'h33);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {24'd0, count}, 32'd7);

    // Full pass-through: one in and one out on the same edge.
    out_ready = 1'b0; in_valid = 1'b1;
    in_imm = 16'h0044; tick();
    in_imm = 16'h0055; tick();
    in_imm = 16'h0066; out_ready = 1'b1; #1;
    chk("pass_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("pass_still_full", {31'd0, in_ready}, 32'd0);
    chk("pass_head", out_imm, 32'h55);
    out_ready = 1'b1;
    tick();
    chk("pass_tail", out_imm, 32'h66);
    tick();
    chk("pass_empty", {31'd0, out_valid}, 32'd0);
    chk("pass_count", {24'd0, count}, 32'd10);

    // Reset mid-operation with buffered data and an input offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_imm = 16'h0077; tick();
    in_imm = 16'h0088; tick();
    rst_n = 1'b0; in_imm = 16'h0099;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_count",     {24'd0, count},     32'd0);
    chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mrst_out_imm",   out_imm,            32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_emit", {31'd0, out_valid}, 32'd0);
    end

    // 257 deliveries: counter wraps through 0 to 1.
    for (int n = 0; n < 257; n++) begin
      in_valid = 1'b1; in_imm = 16'(n); in_mode = MODE_ZERO;
      tick();
      in_valid = 1'b0;
      if (n == 100) chk("stream_value", out_imm, 32'd100);
      tick();
      if (n == 255) chk("wrap_count_0", {24'd0, count}, 32'd0);
    end
    chk("wrap_count_1", {24'd0, count}, 32'd1);

    // 12-bit input build.
    in_valid2 = 1'b1; in_imm2 = 12'h800; in_mode2 = MODE_SIGN;
    tick(); in_valid2 = 1'b0; #1;
    chk("w12_sign", out_imm2, 32'hFFFFF800);
    tick();
    in_valid2 = 1'b1; in_mode2 = MODE_ZERO;
    tick(); in_valid2 = 1'b0; #1;
    chk("w12_zero", out_imm2, 32'h00000800);
    tick();
    in_valid2 = 1'b1; in_mode2 = MODE_UPPER;
    tick(); in_valid2 = 1'b0; #1;
    chk("w12_upper", out_imm2, 32'h80000000);
    tick();
    in_valid2 = 1'b1; in_mode2 = MODE_BRANCH;
    tick(); in_valid2 = 1'b0; #1;
    chk("w12_branch", out_imm2, 32'hFFFFE000);
    tick();
    chk("w12_count", {24'd0, count2}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, giving the immediate input width.
REQ-002 The block SHALL have parameter OUT_W, default 32, giving the extended output width.
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the output buffer entries.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  in_imm/in_mode valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_mode  input  2  extension mode.
REQ-010 out_valid  output  1  out_imm holds a result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_imm  output  OUT_W  extended immediate.
REQ-013 count  output  8  results delivered since reset, modulo 256.

Function
REQ-014 Modes SHALL be: 00 ZERO = IN_W bits zero-padded to OUT_W; 01 SIGN = sign-extended from bit IN_W-1; 10 UPPER = in_imm placed in bits [OUT_W-1:OUT_W-IN_W], low bits zero; 11 BRANCH = sign-extended value shifted left 2.
REQ-015 Parameters SHALL satisfy OUT_W >= IN_W+2 and DEPTH >= 1; elaboration SHALL fail otherwise.
REQ-016 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer when out_valid && out_ready.
REQ-017 The buffer SHALL be a FIFO of DEPTH entries storing already-extended results, with wrap-around read/write pointers and an occupancy counter 0..DEPTH.
REQ-018 in_ready SHALL equal (occupancy < DEPTH) || out_ready; it SHALL NOT depend on in_valid.
REQ-019 A result accepted at edge N SHALL appear on out_imm with out_valid=1 in the cycle after edge N when the buffer was empty (latency 1).
REQ-020 out_valid SHALL equal (occupancy != 0); out_imm SHALL be the head entry and SHALL remain stable while out_valid && !out_ready.
REQ-021 Simultaneous input and output transfers SHALL leave occupancy unchanged, including when full (pass-through) and when occupancy=1.
REQ-022 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-023 count SHALL increment by 1 per output transfer and wrap 255 -> 0.
REQ-024 in_imm/in_mode SHALL be ignored when no input transfer occurs.

Reset
REQ-025 While rst_n=0 at a rising edge: occupancy, pointers and count SHALL become 0; out_valid=0; in_ready=1 the following cycle.
REQ-026 out_imm SHALL read 0 after reset until the first result is written.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; a transfer presented in the reset cycle SHALL NOT be accepted.

Structure
REQ-028 Mode encodings (MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH) SHALL be constants in shared package imm_ext_pkg, reused by the controller decode.
REQ-029 The extension function SHALL be a separate combinational sub-module imm_ext_core (IN_W, OUT_W, mode -> value); imm_extend_unit holds the FIFO, handshake and counter.

Verification
REQ-030 Reset then in_imm=16'h8001 each mode, out_ready=1 -> 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each one cycle after acceptance; count=4.
REQ-031 out_ready=0, push 3 values (DEPTH=2) -> in_ready=0 after 2nd accept, 3rd held; release out_ready -> order preserved, out_imm stable while stalled.
REQ-032 Buffer full, in_valid=1 and out_ready=1 same cycle -> occupancy stays 2, in_ready=1, one in one out.
REQ-033 Deliver 257 results -> count wraps to 1.
REQ-034 Buffer holding 2 entries, rst_n=0 one cycle with in_valid=1 -> out_valid=0, count=0, in_ready=1 next cycle, nothing later emitted from pre-reset data.
REQ-035 Parameters IN_W=12, OUT_W=32, SIGN mode, in_imm=12'h800 -> 32'hFFFFF800; ZERO -> 32'h00000800.
